// File: rtl/ddr_axi_traffic_gen.sv
// ddr_axi_traffic_gen: AXI4 write/read/compare engine for DDR self-test.
// Each pass writes NUM_BURSTS bursts of BURST_LEN beats from BASE_ADDR,
// then reads them back and compares them with a pattern regenerated from
// the beat index. Optional feature macro: TRAFFIC_GEN_LOOP_EN (back-to-back
// passes while start_i is held, rotating the mode; adds loop_cnt_o).
// Ports:
//   clk_i, rst_i (sync, active-high), calib_done_i, start_i, mode_i[1:0]
//   busy_o, done_o, pass_o, err_cnt_o[31:0], first_err_addr_o
//   m_axi_aw*/w*/b*/ar*/r* : flat AXI4 master, one burst outstanding
module ddr_axi_traffic_gen #(
    parameter int              ADDR_WIDTH = 29,
    parameter int              DATA_WIDTH = 64,
    parameter int              ID_WIDTH   = 7,
    parameter int              BURST_LEN  = 16,
    parameter int              NUM_BURSTS = 256,
    parameter longint unsigned BASE_ADDR  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    calib_done_i,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [31:0]             err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
`ifdef TRAFFIC_GEN_LOOP_EN
    output logic [31:0]             loop_cnt_o,
`endif
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(BEAT_BYTES);
    localparam int LOG_DW     = $clog2(DATA_WIDTH);
    localparam longint unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam longint unsigned END_ADDR =
        BASE_ADDR + NUM_BURSTS * BURST_BYTES;
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST = 32'(NUM_BURSTS - 1);

    if (DATA_WIDTH < 32 || DATA_WIDTH > 512 ||
        (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a power of two in 32..512");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
        $error("BURST_LEN must be 1..256");
    end
    if ((64'd4096 % BURST_BYTES) != 0) begin : g_bad_4k
        $error("burst bytes must divide 4096");
    end
    if ((BASE_ADDR % BURST_BYTES) != 0) begin : g_bad_base
        $error("BASE_ADDR must be burst aligned");
    end
    if (END_ADDR > (64'd1 << ADDR_WIDTH)) begin : g_bad_wrap
        $error("pass would wrap the address space");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CAL, S_WR_BURST, S_WR_RESP,
        S_RD_ADDR, S_RD_DATA, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic [8:0]              beat_q, beat_d;
    logic [31:0]             burst_q, burst_d;
    logic [31:0]             g_q, g_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ferr_q, ferr_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
`ifdef TRAFFIC_GEN_LOOP_EN
    logic [31:0]             loop_q, loop_d;
`endif

    // Pattern depends only on mode and global beat index.
    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [1:0] m, input logic [31:0] g);
        logic [DATA_WIDTH-1:0] z;
        z = DATA_WIDTH'(g);
        unique case (m)
            2'd0: pat = z;
            2'd1: pat = g[0] ? {BEAT_BYTES{8'hAA}} : {BEAT_BYTES{8'h55}};
            2'd2: pat = DATA_WIDTH'(1) << g[LOG_DW-1:0];
            default: pat = ~z;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        sat_inc = (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic wlast;
    logic last_exp;
    logic rbad;

    assign wlast = wvalid_q && (beat_q == LAST_BEAT);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        g_d       = g_q;
        addr_d    = addr_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        done_d    = done_q;
        pass_d    = pass_q;
`ifdef TRAFFIC_GEN_LOOP_EN
        loop_d    = loop_q;
`endif
        last_exp  = (beat_q == LAST_BEAT);
        rbad      = (m_axi_rdata != pat(mode_q, g_q)) ||
                    (m_axi_rresp != 2'b00) ||
                    (m_axi_rlast != last_exp);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d   = '0;
                    ferr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    mode_d  = mode_i;
                    beat_d  = '0;
                    burst_d = '0;
                    g_d     = '0;
                    addr_d  = BASE_A;
                    state_d = S_WAIT_CAL;
                end
            end
            S_WAIT_CAL: begin
                if (calib_done_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR_BURST;
                end
            end
            S_WR_BURST: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready) begin
                    g_d = g_q + 32'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d   = '0;
                        wvalid_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
                // A dropped valid means that channel already finished.
                if ((!awvalid_q || m_axi_awready) &&
                    (!wvalid_q || (m_axi_wready && wlast)))
                    state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        if (err_q == '0) ferr_d = addr_q;
                        err_d = sat_inc(err_q);
                    end
                    if (burst_q == LAST_BURST) begin
                        burst_d   = '0;
                        g_d       = '0;
                        addr_d    = BASE_A;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end else begin
                        burst_d   = burst_q + 32'd1;
                        addr_d    = addr_q + STEP;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_BURST;
                    end
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    if (rbad) begin
                        if (err_q == '0)
                            ferr_d = BASE_A +
                                     ADDR_WIDTH'(64'(g_q) << SIZE);
                        err_d = sat_inc(err_q);
                    end
                    g_d    = g_q + 32'd1;
                    beat_d = beat_q + 9'd1;
                    // An early rlast closes the burst; skip its beats.
                    if (last_exp || m_axi_rlast) begin
                        beat_d = '0;
                        g_d    = g_q + 32'(LAST_BEAT - beat_q) + 32'd1;
                        if (burst_q == LAST_BURST) begin
                            state_d = S_DONE;
                        end else begin
                            burst_d   = burst_q + 32'd1;
                            addr_d    = addr_q + STEP;
                            arvalid_d = 1'b1;
                            state_d   = S_RD_ADDR;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
`ifdef TRAFFIC_GEN_LOOP_EN
                loop_d = loop_q + 32'd1;
                if (start_i) begin
                    mode_d  = mode_q + 2'd1;
                    beat_d  = '0;
                    burst_d = '0;
                    g_d     = '0;
                    addr_d  = BASE_A;
                    state_d = S_WAIT_CAL;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            burst_q   <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            err_q     <= '0;
            ferr_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef TRAFFIC_GEN_LOOP_EN
            loop_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            g_q       <= g_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
`ifdef TRAFFIC_GEN_LOOP_EN
            loop_q    <= loop_d;
`endif
        end
    end

    assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = ferr_q;
`ifdef TRAFFIC_GEN_LOOP_EN
    assign loop_cnt_o       = loop_q;
`endif

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = pat(mode_q, g_q);
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_WR_RESP);
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == S_RD_DATA);

endmodule
